// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
//   - opcode constants (ALU_ADD .. ALU_REMU), held at OPC_W bits so any
//     aluCtr width up to OPC_W can be zero-extended and compared directly
//   - FSM state encoding
//   - isMultiCycle(): opcodes that are handled by the shift/restore datapath
package alu_pkg;

    localparam int OPC_W = 8;

    localparam logic [OPC_W-1:0] ALU_ADD  = 8'd0;
    localparam logic [OPC_W-1:0] ALU_SUB  = 8'd1;
    localparam logic [OPC_W-1:0] ALU_AND  = 8'd2;
    localparam logic [OPC_W-1:0] ALU_OR   = 8'd3;
    localparam logic [OPC_W-1:0] ALU_XOR  = 8'd4;
    localparam logic [OPC_W-1:0] ALU_SLT  = 8'd5;
    localparam logic [OPC_W-1:0] ALU_SLTU = 8'd6;
    localparam logic [OPC_W-1:0] ALU_SLL  = 8'd7;
    localparam logic [OPC_W-1:0] ALU_SRL  = 8'd8;
    localparam logic [OPC_W-1:0] ALU_SRA  = 8'd9;
    localparam logic [OPC_W-1:0] ALU_MUL  = 8'd10;
    localparam logic [OPC_W-1:0] ALU_DIVU = 8'd11;
    localparam logic [OPC_W-1:0] ALU_REMU = 8'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } aluStateT;

    function automatic logic isMultiCycle(input logic [OPC_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (low word) / restoring divide datapath.
// One step per cycle while step=1; WIDTH steps complete an operation.
//   clk, rst_n : clock, async active-low reset
//   load       : latch op/a/b, clear accumulator, counter=WIDTH
//   op         : ALU_MUL, ALU_DIVU or ALU_REMU
//   a, b       : operands
//   step       : advance one iteration
//   res        : result as it will be AFTER the current step; the owner
//                samples it on the step where last=1
//   last       : the current step is the final one (counter==1)
// Register reuse: for MUL regA=multiplicand, regB=multiplier, acc=product;
// for DIV regA=dividend shifting into quotient, regB=divisor, acc=remainder.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [OPC_W-1:0] op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] res,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [OPC_W-1:0] opReg;
    logic [WIDTH-1:0] regA, regB, acc;
    logic [WIDTH-1:0] nA, nB, nAcc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rShift;
    logic [WIDTH-1:0] diff;
    logic             geq;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The partial remainder needs one
    // extra bit before the compare; after subtraction it is < divisor.
    assign rShift = {acc, regA[WIDTH-1]};
    assign geq    = rShift >= {1'b0, regB};
    assign diff   = rShift[WIDTH-1:0] - regB;

    always_comb begin
        nA   = regA;
        nB   = regB;
        nAcc = acc;
        if (opReg == ALU_MUL) begin
            if (regB[0]) nAcc = acc + regA;
            nA = regA << 1;
            nB = regB >> 1;
        end else begin
            if (geq) begin
                nAcc = diff;
                nA   = {regA[WIDTH-2:0], 1'b1};
            end else begin
                nAcc = rShift[WIDTH-1:0];
                nA   = {regA[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divide by zero falls out naturally: every compare succeeds, so the
    // quotient is all ones and the remainder accumulates the dividend.
    always_comb begin
        res = '0;
        case (opReg)
            ALU_MUL:  res = nAcc;
            ALU_DIVU: res = nA;
            ALU_REMU: res = nAcc;
            default:  res = '0;
        endcase
    end

    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg <= '0;
            regA  <= '0;
            regB  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            opReg <= op;
            regA  <= a;
            regB  <= b;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
        end else if (step) begin
            regA  <= nA;
            regB  <= nB;
            acc   <= nAcc;
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with single-cycle logic/arith/shift ops and iterative
// MUL (low word), DIVU and REMU behind a start/busy/done handshake.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled when busy=0 (also in the DONE cycle)
//   aluCtr     : opcode, srcA/srcB operands, all sampled with start
//   busy       : iterative operation in progress
//   done       : one-cycle pulse, aluRes valid
//   aluRes     : registered result
//   divByZero  : DIVU/REMU with srcB==0, valid with done
// Build option ALU_ITER_EARLY_OUT_EN: MUL with a zero operand and
// DIVU/REMU by zero complete in one cycle instead of WIDTH+1.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CTRL_W  = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CTRL_W-1:0] aluCtr,
    input  logic [WIDTH-1:0]  srcA,
    input  logic [WIDTH-1:0]  srcB,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  aluRes,
    output logic              divByZero
);

    aluStateT         state, nextState;
    logic [OPC_W-1:0] opc;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] singleRes, seqRes;
    logic             seqLast;
    logic             load, step, accept;
    logic             earlyOut, isDiv, dbzFlag;

    assign opc   = OPC_W'(aluCtr);
    assign shamt = srcB[SHAMT_W-1:0];
    assign isDiv = (opc == ALU_DIVU) || (opc == ALU_REMU);

`ifdef ALU_ITER_EARLY_OUT_EN
    assign earlyOut = ((opc == ALU_MUL) && ((srcA == '0) || (srcB == '0))) ||
                      (isDiv && (srcB == '0));
`else
    assign earlyOut = 1'b0;
`endif

    // Single-cycle results. The MUL/DIVU/REMU entries are only reached via
    // the early-out path, i.e. a zero operand / zero divisor.
    always_comb begin
        singleRes = '0;
        case (opc)
            ALU_ADD:  singleRes = srcA + srcB;
            ALU_SUB:  singleRes = srcA - srcB;
            ALU_AND:  singleRes = srcA & srcB;
            ALU_OR:   singleRes = srcA | srcB;
            ALU_XOR:  singleRes = srcA ^ srcB;
            ALU_SLT:  singleRes = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            ALU_SLTU: singleRes = {{(WIDTH-1){1'b0}}, srcA < srcB};
            ALU_SLL:  singleRes = srcA << shamt;
            ALU_SRL:  singleRes = srcA >> shamt;
            ALU_SRA:  singleRes = $unsigned($signed(srcA) >>> shamt);
            ALU_MUL:  singleRes = '0;
            ALU_DIVU: singleRes = '1;
            ALU_REMU: singleRes = srcA;
            default:  singleRes = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
    always_comb begin
        nextState = state;
        load      = 1'b0;
        step      = 1'b0;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (state == DONE) nextState = IDLE;
                if (start) begin
                    accept = 1'b1;
                    if (isMultiCycle(opc) && !earlyOut) begin
                        load      = 1'b1;
                        nextState = CALC;
                    end else begin
                        nextState = DONE;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (seqLast) nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    // aluRes keeps the previous result while an iterative op runs; the
    // divide-by-zero condition is captured at issue and published at done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluRes    <= '0;
            divByZero <= 1'b0;
            dbzFlag   <= 1'b0;
        end else if (accept) begin
            dbzFlag <= isDiv && (srcB == '0);
            if (load) begin
                divByZero <= 1'b0;
            end else begin
                aluRes    <= singleRes;
                divByZero <= isDiv && (srcB == '0);
            end
        end else if ((state == CALC) && seqLast) begin
            aluRes    <= seqRes;
            divByZero <= dbzFlag;
        end
    end

    alu_muldiv_seq #(.WIDTH(WIDTH)) uSeq (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .op    (opc),
        .a     (srcA),
        .b     (srcB),
        .step  (step),
        .res   (seqRes),
        .last  (seqLast)
    );

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, registered successor to the combinational datapath ALU in the multi-cycle processor.
- Adds XOR, correct signed/unsigned set-less-than, and three shifts.
- Adds iterative unsigned multiply (low word), divide and remainder, with a start/busy/done handshake.
- The multi-cycle controller issues one operation and stalls on busy until done pulses.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
CTRL_W, 4, width of aluCtr opcode field
SHAMT_W, $clog2(WIDTH), number of low srcB bits used as shift amount

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only when busy=0
aluCtr  input  CTRL_W  opcode, sampled with start
srcA  input  WIDTH  operand A, sampled with start
srcB  input  WIDTH  operand B, sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: aluRes valid
aluRes  output  WIDTH  registered result, held until next accepted start
divByZero  output  1  set with done when a DIVU/REMU had srcB==0

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, aluRes=0, divByZero=0, all internal registers cleared. Reset mid-operation aborts it silently; no done is produced.
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL, 1011 DIVU, 1100 REMU. Any other opcode gives result 0 on the single-cycle path.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU return 1 in the LSB, zeros elsewhere, when A<B.
  - Shifts use srcB[SHAMT_W-1:0].
  - MUL returns the low WIDTH bits of the unsigned product.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 with a single-cycle opcode: compute and register aluRes, go to DONE. busy is never asserted; done=1 in the next cycle (latency 1).
  - start=1 with MUL/DIVU/REMU: latch operands, load counter=WIDTH, busy=1, go to CALC.
- CALC:
  - MUL: one shift-add step per cycle.
  - DIVU/REMU: one restoring-division step per cycle.
  - Counter decrements each cycle. At counter==1, register the result, busy=0, go to DONE.
  - Total latency from start to done: WIDTH+1 cycles.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is accepted as a new operation, giving back-to-back issue.
- start while busy=1 is ignored; operands and opcode changes during CALC have no effect.
- Divide by zero: DIVU gives all ones, REMU gives srcA, divByZero=1. divByZero is cleared on the next accepted start.
- Boundary cases:
  - Shift amount 0 returns srcA.
  - SRA of a negative value fills with ones.
  - DIVU with srcA < srcB gives 0, remainder srcA.

Optional Feature:
- Macro: ALU_ITER_EARLY_OUT_EN.
- Defined: MUL with either operand 0, and DIVU/REMU with srcB==0, bypass CALC. They go directly to DONE with latency 1 and the same result values as above.
- Undefined: every MUL/DIVU/REMU takes WIDTH+1 cycles regardless of operand values.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ALU_ADD ... ALU_REMU);
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - function isMultiCycle(opcode).
- One sub-module: alu_muldiv_seq.
  - Holds the shift-add/restoring datapath and iteration counter.
  - Interface: load, op, a, b, step, outputs res, last.
  - alu_iter holds the FSM, handshake and the single-cycle combinational ops.

Test Plan:
- Reset pulse during MUL CALC (cycle 5) -> busy=0, done never asserts, aluRes=0; next ADD 3+4 -> done one cycle later, aluRes=7.
- SLT srcA=0xFFFFFFFF, srcB=1 -> aluRes=1; SLTU same operands -> aluRes=0; SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 0x0001_0003 x 0x0000_0005 (WIDTH=32) -> busy for 32 cycles, done at cycle 33, aluRes=0x0005_000F; start pulses during busy are ignored.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF with divByZero=1; REMU 5/0 -> 5.
- Back-to-back: start ADD in the DONE cycle of a DIVU -> ADD done the following cycle, DIVU result seen for exactly one done pulse.
- With ALU_ITER_EARLY_OUT_EN: MUL x*0 -> done in 1 cycle, aluRes=0; without the macro -> 33 cycles, same result.
